// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state type and sizing helper for the sequential divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division step
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   part_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // A set top bit means the shifted value already exceeds any WIDTH-bit divisor.
    always_comb begin
        shifted   = {part[WIDTH-1:0], bit_in};
        diff      = shifted - {1'b0, divisor};
        q_bit     = part[WIDTH] || (shifted >= {1'b0, divisor});
        part_next = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/seq_div_mod.sv
// rtl/seq_div_mod.sv - multi-cycle restoring divider, one quotient bit per clock
module seq_div_mod
    import seq_div_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             _go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             q_neg;
    logic             r_neg;
    logic             zero_div;

    logic             left_neg;
    logic             right_neg;
    logic [WIDTH-1:0] left_mag;
    logic [WIDTH-1:0] right_mag;
    logic [WIDTH:0]   part_next;
    logic             q_bit;

    always_comb begin
        left_neg  = SIGNED && left[WIDTH-1];
        right_neg = SIGNED && right[WIDTH-1];
        left_mag  = left_neg  ? -left  : left;
        right_mag = right_neg ? -right : right;
    end

    // dvd doubles as the quotient register: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    seq_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .part     (part),
        .bit_in   (dvd[WIDTH-1]),
        .divisor  (dsr),
        .part_next(part_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            part        <= '0;
            dvd         <= '0;
            dsr         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero_div    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (_go) begin
                        part     <= '0;
                        cnt      <= CW'(WIDTH);
                        dvd      <= left_mag;
                        dsr      <= right_mag;
                        q_neg    <= left_neg ^ right_neg;
                        r_neg    <= left_neg;
                        zero_div <= (right == '0);
                        ready    <= 1'b0;
                        state    <= CALC;
                    end else begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    part <= part_next;
                    dvd  <= {dvd[WIDTH-2:0], q_bit};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor already yields an all-ones magnitude; force it
                    // so the sign fix-up cannot turn it into something else.
                    quot        <= zero_div ? '1 : (q_neg ? -dvd : dvd);
                    rem         <= r_neg ? -part[WIDTH-1:0] : part[WIDTH-1:0];
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                    ready       <= 1'b1;
                    state       <= DONE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_mod.sv
// tb/tb_seq_div_mod.sv - randomized self-checking bench for seq_div_mod, unsigned and signed
module tb_seq_div_mod;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [W-1:0] left;
    logic [W-1:0] right;

    logic         ready_u, done_u, dbz_u;
    logic [W-1:0] quot_u, rem_u;
    logic         ready_s, done_s, dbz_s;
    logic [W-1:0] quot_s, rem_s;

    int n_checks = 0;
    int n_pass   = 0;

    seq_div_mod #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), ._go(go), .left(left), .right(right),
        .ready(ready_u), .done(done_u), .quot(quot_u), .rem(rem_u), .div_by_zero(dbz_u)
    );

    seq_div_mod #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), ._go(go), .left(left), .right(right),
        .ready(ready_s), .done(done_s), .quot(quot_s), .rem(rem_s), .div_by_zero(dbz_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer division, C-style truncation toward zero.
    function automatic void model(input bit sgn, input logic [W-1:0] l, input logic [W-1:0] r,
                                  output logic [W-1:0] q, output logic [W-1:0] rm,
                                  output logic z);
        int a;
        int b;
        if (sgn) begin
            a = int'($signed(l));
            b = int'($signed(r));
        end else begin
            a = int'(l);
            b = int'(r);
        end
        z = (b == 0);
        if (b == 0) begin
            q  = '1;
            rm = l;
        end else begin
            q  = W'(a / b);
            rm = W'(a % b);
        end
    endfunction

    // Called away from the clock edge with both units ready; returns in the DONE cycle.
    task automatic op(input logic [W-1:0] l, input logic [W-1:0] r, input bit hold, input string tag);
        logic [W-1:0] qe, re;
        logic         ze;
        int           lat;
        go    = 1'b1;
        left  = l;
        right = r;
        @(posedge clk); #1;
        lat = 1;
        check({tag, "_busy"}, {ready_u, ready_s}, 2'b00);
        if (!hold) go = 1'b0;
        while (!done_u && lat < 20) begin
            if (hold) begin
                left  = W'($urandom);
                right = W'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        go = 1'b0;
        check({tag, "_lat"}, lat, W + 2);
        check({tag, "_done_s"}, done_s, 1'b1);
        check({tag, "_ready"}, {ready_u, ready_s}, 2'b11);
        model(1'b0, l, r, qe, re, ze);
        check({tag, "_uq"}, quot_u, qe);
        check({tag, "_ur"}, rem_u, re);
        check({tag, "_uz"}, dbz_u, ze);
        model(1'b1, l, r, qe, re, ze);
        check({tag, "_sq"}, quot_s, qe);
        check({tag, "_sr"}, rem_s, re);
        check({tag, "_sz"}, dbz_s, ze);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("done_pulse_width", {done_u, done_s}, 2'b00);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_u"}, {ready_u, done_u, dbz_u, quot_u, rem_u}, {1'b1, 2'b00, 16'h0});
        check({tag, "_s"}, {ready_s, done_s, dbz_s, quot_s, rem_s}, {1'b1, 2'b00, 16'h0});
    endtask

    initial begin
        int           seen;
        logic [W-1:0] l, r;
        reset = 1'b1;
        go    = 1'b0;
        left  = '0;
        right = '0;
        #1;
        check_cleared("reset_state");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle(1);

        op(8'd100, 8'd7, 1'b0, "u100_7");
        check("q100_7", quot_u, 8'd14);
        check("r100_7", rem_u, 8'd2);
        idle(3);
        check("hold_q", {quot_u, rem_u}, {8'd14, 8'd2});

        op(8'hF9, 8'h02, 1'b0, "m7_2");
        check("sq_m7_2", {quot_s, rem_s}, 16'hFDFF);
        idle(1);

        op(8'h55, 8'h00, 1'b0, "div0");
        check("div0_const", {quot_u, rem_u, dbz_u}, {8'hFF, 8'h55, 1'b1});
        idle(1);

        op(8'h80, 8'hFF, 1'b0, "minneg");
        check("minneg_const", {quot_s, rem_s, dbz_s}, {8'h80, 8'h00, 1'b0});
        idle(1);

        op(8'd200, 8'd3, 1'b1, "hold200_3");
        check("q200_3", {quot_u, rem_u}, {8'd66, 8'd2});
        op(8'd9, 8'd4, 1'b0, "b2b9_4");
        check("q9_4", {quot_u, rem_u}, {8'd2, 8'd1});
        idle(2);

        go    = 1'b1;
        left  = 8'd77;
        right = 8'd3;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check_cleared("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done_u || done_s) seen++;
        end
        check("no_done_after_reset", seen, 0);
        op(8'd50, 8'd5, 1'b0, "after_reset");
        check("q50_5", {quot_u, rem_u}, {8'd10, 8'd0});

        for (int k = 0; k < 40; k++) begin
            l = W'($urandom);
            case ($urandom_range(0, 7))
                0:       r = 8'h00;
                1:       r = 8'hFF;
                2:       begin l = 8'h80; r = W'($urandom); end
                default: r = W'($urandom);
            endcase
            op(l, r, 1'b0, "rnd");
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
